// File: rtl/dnoc_param_fifo.sv
// dnoc_param_fifo
//   Single-clock show-ahead FIFO with occupancy count and almost-full /
//   almost-empty thresholds.
//
//   Optional feature: define DNOC_FIFO_ERR_EN to add the sticky
//   overflow/underflow flags and their err_clr input.
//
//   Ports
//     clk           rising-edge clock
//     rst           asynchronous active-high reset
//     flush         synchronous clear of pointers and count
//     push/in_data  write request and data
//     full          no free entry
//     almost_full   count >= AF_LVL
//     pop           read request
//     out_data      head entry, valid whenever empty=0
//     empty         no valid entry
//     almost_empty  count <= AE_LVL
//     count         current occupancy
//     overflow      sticky, push seen while full     (DNOC_FIFO_ERR_EN)
//     underflow     sticky, pop seen while empty     (DNOC_FIFO_ERR_EN)
//     err_clr       clears overflow/underflow        (DNOC_FIFO_ERR_EN)
module dnoc_param_fifo #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     pop,
  output logic [DATA_W-1:0]        out_data,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef DNOC_FIFO_ERR_EN
  ,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full  = (count >= (AW+1)'(AF_LVL));
  assign almost_empty = (count <= (AW+1)'(AE_LVL));
  assign out_data     = mem[rd_ptr[AW-1:0]];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so out_data reads 0 before any write;
  // flush leaves contents untouched and drops a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && push_ok) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

`ifdef DNOC_FIFO_ERR_EN
  // A set condition in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (pop && empty)  underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dnoc_param_fifo.sv
module tb_dnoc_param_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration instance
  logic       rst, flush, push, pop, ec;
  logic [1:0] in_data, out_data;
  logic       full, almost_full, empty, almost_empty;
  logic [4:0] count;
`ifdef DNOC_FIFO_ERR_EN
  logic overflow, underflow;
`endif

  // small wide configuration instance
  logic        rst32, flush32, push32, pop32, ec32;
  logic [31:0] in32, out32;
  logic        full32, af32, empty32, ae32;
  logic [2:0]  count32;
`ifdef DNOC_FIFO_ERR_EN
  logic ov32, uf32;
`endif

  dnoc_param_fifo u_dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .in_data(in_data),
    .full(full), .almost_full(almost_full), .pop(pop), .out_data(out_data),
    .empty(empty), .almost_empty(almost_empty), .count(count)
`ifdef DNOC_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow), .err_clr(ec)
`endif
  );

  dnoc_param_fifo #(.DATA_W(32), .DEPTH(4), .AF_LVL(3), .AE_LVL(0)) u_dut32 (
    .clk(clk), .rst(rst32), .flush(flush32), .push(push32), .in_data(in32),
    .full(full32), .almost_full(af32), .pop(pop32), .out_data(out32),
    .empty(empty32), .almost_empty(ae32), .count(count32)
`ifdef DNOC_FIFO_ERR_EN
    , .overflow(ov32), .underflow(uf32), .err_clr(ec32)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [1:0]  q[$];
  logic [31:0] q32[$];
  logic        m_ov, m_uf;

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  // One clock of stimulus on the default instance; the queue model is the
  // reference and every output is compared after the edge.
  task automatic cycle(input logic p, input logic po, input logic f,
                       input logic [1:0] d, input logic c);
    logic m_full, m_empty;
    push = p; pop = po; flush = f; in_data = d; ec = c;
    m_full  = (q.size() == 16);
    m_empty = (q.size() == 0);
    if (po && !m_empty && !f) chk("pop_data", 32'(out_data), 32'(q[0]));
    @(posedge clk); #1;
    if (f) q.delete();
    else begin
      if (po && !m_empty) void'(q.pop_front());
      if (p && !m_full) q.push_back(d);
    end
    if (p && m_full) m_ov = 1'b1; else if (c) m_ov = 1'b0;
    if (po && m_empty) m_uf = 1'b1; else if (c) m_uf = 1'b0;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 12));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    if (q.size() != 0) chk("head", 32'(out_data), 32'(q[0]));
`ifdef DNOC_FIFO_ERR_EN
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_uf));
`endif
    push = 0; pop = 0; flush = 0; ec = 0;
  endtask

  task automatic cycle32(input logic p, input logic po, input logic f, input logic [31:0] d);
    logic m_full, m_empty;
    push32 = p; pop32 = po; flush32 = f; in32 = d;
    m_full  = (q32.size() == 4);
    m_empty = (q32.size() == 0);
    if (po && !m_empty && !f) chk("pop_data32", out32, q32[0]);
    @(posedge clk); #1;
    if (f) q32.delete();
    else begin
      if (po && !m_empty) void'(q32.pop_front());
      if (p && !m_full) q32.push_back(d);
    end
    chk("count32", 32'(count32), 32'(q32.size()));
    chk("empty32", 32'(empty32), 32'(q32.size() == 0));
    chk("full32", 32'(full32), 32'(q32.size() == 4));
    chk("af32", 32'(af32), 32'(q32.size() >= 3));
    chk("ae32", 32'(ae32), 32'(q32.size() == 0));
    push32 = 0; pop32 = 0; flush32 = 0;
  endtask

  typedef struct {
    logic p, po, f;
    logic [1:0] d;
    int   cnt;
    logic emp, ae, co;
    logic [1:0] out;
  } vec_t;

  vec_t tbl[11];

  initial begin
    //          p  po f  d  cnt emp ae co out
    tbl[0]  = '{1, 0, 0, 1, 1,  0,  1, 1, 1};
    tbl[1]  = '{1, 0, 0, 2, 2,  0,  1, 1, 1};
    tbl[2]  = '{1, 0, 0, 3, 3,  0,  0, 1, 1};
    tbl[3]  = '{1, 1, 0, 0, 3,  0,  0, 1, 2};
    tbl[4]  = '{0, 1, 0, 0, 2,  0,  1, 1, 3};
    tbl[5]  = '{0, 1, 0, 0, 1,  0,  1, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 0,  1,  1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0,  1,  1, 0, 0};
    tbl[8]  = '{1, 1, 0, 2, 1,  0,  1, 1, 2};
    tbl[9]  = '{1, 0, 1, 3, 0,  1,  1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0,  1,  1, 0, 0};

    m_ov = 0; m_uf = 0;
    rst = 1; flush = 0; push = 0; pop = 0; in_data = 0; ec = 0;
    rst32 = 1; flush32 = 0; push32 = 0; pop32 = 0; in32 = 0; ec32 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_out", 32'(out_data), 0);
`ifdef DNOC_FIFO_ERR_EN
    chk("rst_ov", 32'(overflow), 0);
    chk("rst_uf", 32'(underflow), 0);
`endif
    @(negedge clk); rst = 0;

    // table-driven short sequence
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].p, tbl[i].po, tbl[i].f, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_ae", i), 32'(almost_empty), 32'(tbl[i].ae));
      chk($sformatf("tbl%0d_full", i), 32'(full), 0);
      if (tbl[i].co) chk($sformatf("tbl%0d_out", i), 32'(out_data), 32'(tbl[i].out));
    end
    cycle(0, 0, 0, 0, 1'b1);  // clear any sticky flag from the table

    // fill to full with 0,1,2,3,...
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 2'(i), 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    cycle(1, 0, 0, 2'd3, 1'b0);          // rejected, sets overflow
    cycle(1, 0, 0, 2'd3, 1'b1);          // set beats clear
    cycle(0, 0, 0, 2'd0, 1'b1);          // clear

    // drain, then one extra pop
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(out_data), 32'(i % 4));
      cycle(0, 1, 0, 0, 1'b0);
    end
    chk("drain_empty", 32'(empty), 1);
    cycle(0, 1, 0, 0, 1'b0);
    cycle(0, 0, 0, 0, 1'b1);

    // steady push+pop at count 5, wraps the pointers
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 2'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 0, 2'($urandom), 1'b0);
      chk("steady_count", 32'(count), 5);
    end

    // push+pop at full: push dropped
    for (int i = 0; i < 11; i++) cycle(1, 0, 0, 2'($urandom), 1'b0);
    cycle(1, 1, 0, 2'd3, 1'b0);
    chk("fullpp_count", 32'(count), 15);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0, 1'b0);
    // push+pop at empty: push taken
    cycle(1, 1, 0, 2'd1, 1'b0);
    chk("emptypp_count", 32'(count), 1);
    chk("emptypp_out", 32'(out_data), 1);
    cycle(0, 1, 0, 0, 1'b1);

    // flush with push at count 7
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 2'(i), 1'b0);
    cycle(1, 0, 1, 2'd3, 1'b0);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    cycle(1, 0, 0, 2'd2, 1'b0);
    chk("post_flush_out", 32'(out_data), 2);
    cycle(0, 1, 0, 0, 1'b0);

    // async reset mid-burst at count 9
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 2'(i + 1), 1'b0);
    #2 rst = 1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_ae", 32'(almost_empty), 1);
    chk("arst_af", 32'(almost_full), 0);
    chk("arst_out", 32'(out_data), 0);
    q.delete(); m_ov = 0; m_uf = 0;
    @(negedge clk); rst = 0;
    cycle(1, 0, 0, 2'd3, 1'b0);
    chk("post_rst_out", 32'(out_data), 3);

    // wide configuration, random scoreboard
    @(negedge clk); rst32 = 0;
    chk("rst32_empty", 32'(empty32), 1);
    for (int i = 0; i < 10000; i++)
      cycle32($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 31) == 0, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
